actf_pipe: RTL and testbench
============================

Name: actf_pipe

Overview:
- Parametrised, pipelined successor to the single-lane sigmoid activation stage.
- Applies a run-time selectable activation (PLAN sigmoid, ReLU, leaky ReLU, identity) to NCH fixed-point lanes in parallel.
- Uses valid/ready handshakes on both sides.
- Sits between the neuron accumulator/adder tree and the next layer's input buffer.

Parameters:
- DWIDTH, 32, lane width, signed two's complement.
- FRAC, 24, fractional bits (Q(DWIDTH-FRAC).FRAC); must be >= 5.
- NCH, 4, number of parallel lanes.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  global advance enable; 0 freezes the pipeline.
- mode  input  2  00 sigmoid, 01 ReLU, 10 identity, 11 leaky ReLU; sampled with in_valid&&in_ready.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  NCH*DWIDTH  packed lanes; lane k = bits [k*DWIDTH +: DWIDTH].
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  NCH*DWIDTH  packed results.
- sat_cnt  output  16  saturated-sigmoid lane count (optional feature).
- sat_clr  input  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (reset=0, async):
  - All stage valids=0; out_data=0; sat_cnt=0.
  - in_ready=0 while reset is asserted.
- Pipeline: 2 register stages.
  - S1 registers |x|, sign, segment index, mode and valid per lane.
  - S2 computes the result, applies sign correction and drives out_*.
  - Latency is 2 cycles from an accepted beat to out_valid with no stall.
- Advance rule: adv = en && (!out_valid || out_ready).
  - in_ready = adv.
  - When adv=0, S1/S2 hold; out_data is stable while out_valid=1 and out_ready=0.
  - Throughput is 1 beat/cycle.
- en=0: no register changes; in_ready=0; out_valid held.
- Sigmoid (PLAN), with a=|x|:
  - a >= 5.0 -> 1.0.
  - 2.375 <= a < 5 -> a>>5 + 0.84375.
  - 1 <= a < 2.375 -> a>>3 + 0.625.
  - a < 1 -> a>>2 + 0.5.
  - x < 0 -> 1.0 - y.
  - Constants are built as integer<<(FRAC-k); shifts are logical on a.
  - abs(most negative value) saturates to the max positive value, which lands in the saturated segment.
- ReLU: x<0 -> 0, else x.
- Leaky ReLU: x<0 -> x>>>3 (arithmetic, floor), else x.
- Identity: out=x.
- Mode is per beat: a mode change mid-stream affects only beats accepted after the change.
- Lanes are independent; all share mode and the handshake.
- Reset mid-operation: in-flight beats are discarded; no output is produced for them.

Optional Feature:
- Macro: ACTF_SAT_COUNT_EN.
- Defined:
  - sat_cnt increments by the number of lanes in a beat that leave S2 (out_valid&&out_ready) in sigmoid mode with a >= 5.0.
  - The counter saturates at 0xFFFF.
  - sat_clr=1 zeroes it on the next edge; clear wins over a simultaneous increment.
- Undefined: sat_cnt is tied to 0, sat_clr is ignored, and no counter logic is present.

Test Plan:
- NCH=4, FRAC=24, mode=00, lanes {0x00000000, 0x01000000, 0xFF000000, 0x02600000} -> after 2 cycles out = {0x00800000, 0x00C00000, 0x00400000, 0x00EB0000}.
- Sigmoid saturation: lanes {6.0, -6.0, 0x7FFFFFFF, 0x80000000} -> {0x01000000, 0x00000000, 0x01000000, 0x00000000}; with ACTF_SAT_COUNT_EN, sat_cnt=4.
- mode=01 then mode=11 on consecutive beats, lane0 = -2.0 (0xFE000000) -> 0x00000000, then 0xFFC00000; positive lane 3.0 passes unchanged in both.
- Back-pressure: stream 5 beats with out_ready low for cycles 3-6 -> out_data held, in_ready=0 during the stall, no beat lost or duplicated, order preserved.
- en=0 for 3 cycles mid-stream -> all state frozen; on resume, results match the unstalled golden model.
- Assert reset for 1 cycle while 2 beats are in flight -> out_valid=0 and out_data=0 immediately; sat_cnt=0; the next accepted beat emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/actf_pipe.sv
// Two-stage pipelined multi-lane activation unit (PLAN sigmoid, ReLU, identity, leaky ReLU).
// Optional saturated-sigmoid lane counter enabled by defining ACTF_SAT_COUNT_EN.
module actf_pipe #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned FRAC   = 24,
  parameter int unsigned NCH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DWIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DWIDTH-1:0] out_data,
  output logic [15:0]           sat_cnt,
  input  logic                  sat_clr
);

  localparam int unsigned W = NCH * DWIDTH;

  localparam logic [DWIDTH-1:0] ONE     = DWIDTH'(1) << FRAC;
  localparam logic [DWIDTH-1:0] HALF    = DWIDTH'(1) << (FRAC - 1);
  localparam logic [DWIDTH-1:0] TH_SAT  = DWIDTH'(5) << FRAC;        // 5.0
  localparam logic [DWIDTH-1:0] TH_MID  = DWIDTH'(19) << (FRAC - 3); // 2.375
  localparam logic [DWIDTH-1:0] C_SEG2  = DWIDTH'(27) << (FRAC - 5); // 0.84375
  localparam logic [DWIDTH-1:0] C_SEG1  = DWIDTH'(5) << (FRAC - 3);  // 0.625
  localparam logic [DWIDTH-1:0] MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    M_SIG   = 2'b00,
    M_RELU  = 2'b01,
    M_ID    = 2'b10,
    M_LEAKY = 2'b11
  } mode_e;

  logic adv;

  // Stage 1 state
  logic              s1_valid;
  mode_e             s1_mode;
  logic [DWIDTH-1:0] s1_x    [NCH];
  logic [DWIDTH-1:0] s1_a    [NCH];
  logic              s1_sign [NCH];
  logic [1:0]        s1_seg  [NCH];

  logic [DWIDTH-1:0] x_c   [NCH];
  logic [DWIDTH-1:0] a_c   [NCH];
  logic [1:0]        seg_c [NCH];
  logic [W-1:0]      y_c;

  assign adv      = en && (!out_valid || out_ready);
  assign in_ready = adv && reset;

  // Magnitude and segment classification; |MIN| saturates into the top segment.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      x_c[k] = in_data[k*DWIDTH +: DWIDTH];
      if (x_c[k] == MIN_NEG)      a_c[k] = MAX_POS;
      else if (x_c[k][DWIDTH-1])  a_c[k] = -x_c[k];
      else                        a_c[k] = x_c[k];
      if (a_c[k] >= TH_SAT)       seg_c[k] = 2'd3;
      else if (a_c[k] >= TH_MID)  seg_c[k] = 2'd2;
      else if (a_c[k] >= ONE)     seg_c[k] = 2'd1;
      else                        seg_c[k] = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= M_SIG;
      for (int k = 0; k < NCH; k++) begin
        s1_x[k]    <= '0;
        s1_a[k]    <= '0;
        s1_sign[k] <= 1'b0;
        s1_seg[k]  <= 2'd0;
      end
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode_e'(mode);
        for (int k = 0; k < NCH; k++) begin
          s1_x[k]    <= x_c[k];
          s1_a[k]    <= a_c[k];
          s1_sign[k] <= x_c[k][DWIDTH-1];
          s1_seg[k]  <= seg_c[k];
        end
      end
    end
  end

  // Per-lane result selection with sign correction for the sigmoid.
  always_comb begin
    logic [DWIDTH-1:0] yp;
    logic [DWIDTH-1:0] lane;
    y_c = '0;
    for (int k = 0; k < NCH; k++) begin
      yp   = '0;
      lane = '0;
      case (s1_seg[k])
        2'd3:    yp = ONE;
        2'd2:    yp = (s1_a[k] >> 5) + C_SEG2;
        2'd1:    yp = (s1_a[k] >> 3) + C_SEG1;
        default: yp = (s1_a[k] >> 2) + HALF;
      endcase
      if (s1_sign[k]) yp = ONE - yp;
      case (s1_mode)
        M_SIG:   lane = yp;
        M_RELU:  lane = s1_sign[k] ? '0 : s1_x[k];
        M_LEAKY: lane = s1_sign[k] ? $unsigned($signed(s1_x[k]) >>> 3) : s1_x[k];
        default: lane = s1_x[k];
      endcase
      y_c[k*DWIDTH +: DWIDTH] = lane;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= y_c;
    end
  end

`ifdef ACTF_SAT_COUNT_EN
  logic [NCH-1:0] s2_sat;
  logic [NCH-1:0] sat_c;
  logic [16:0]    sat_sum_c;

  always_comb begin
    sat_c = '0;
    for (int k = 0; k < NCH; k++) sat_c[k] = (s1_mode == M_SIG) && (s1_seg[k] == 2'd3);
  end

  // Lanes counted only when the beat actually leaves stage 2.
  always_comb begin
    sat_sum_c = {1'b0, sat_cnt};
    if (en && out_valid && out_ready) begin
      for (int k = 0; k < NCH; k++) sat_sum_c = sat_sum_c + 17'(s2_sat[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_sat  <= '0;
      sat_cnt <= '0;
    end else begin
      if (adv && s1_valid) s2_sat <= sat_c;
      if (sat_clr)           sat_cnt <= '0;
      else if (sat_sum_c[16]) sat_cnt <= 16'hFFFF;
      else                    sat_cnt <= sat_sum_c[15:0];
    end
  end
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_actf_pipe.sv
// Directed bench for actf_pipe: vector table, mode switching, back-pressure, en stall, sat counter, reset.
module tb_actf_pipe;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = NCH * DW;
`ifdef ACTF_SAT_COUNT_EN
  localparam bit SATEN = 1'b1;
`else
  localparam bit SATEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   sat_cnt;
  logic          sat_clr;

  actf_pipe #(.DWIDTH(DW), .FRAC(24), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  vec_t         tv [7];
  int           checks = 0;
  int           errors = 0;
  int           tx_cnt = 0;
  int           rx_cnt = 0;
  int           discarded = 0;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        tx_cnt++;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", W'(0), W'(1));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) step();
    step();
    chk("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  // Output scoreboard: every transferred beat must match the next expected beat.
  always @(negedge clk) begin
    if (reset && en && out_valid && out_ready) begin
      rx_cnt++;
      if (exp_q.size() == 0) chk("unexpected_beat", out_data, W'(0));
      else chk("stream", out_data, exp_q.pop_front());
    end
  end

  initial begin
    tv[0] = '{2'b00, pk(32'h00000000, 32'h01000000, 32'hFF000000, 32'h02600000),
                     pk(32'h00800000, 32'h00C00000, 32'h00400000, 32'h00EB0000)};
    tv[1] = '{2'b00, pk(32'h06000000, 32'hFA000000, 32'h7FFFFFFF, 32'h80000000),
                     pk(32'h01000000, 32'h00000000, 32'h01000000, 32'h00000000)};
    tv[2] = '{2'b01, pk(32'hFE000000, 32'h03000000, 32'h00000000, 32'h80000000),
                     pk(32'h00000000, 32'h03000000, 32'h00000000, 32'h00000000)};
    tv[3] = '{2'b11, pk(32'hFE000000, 32'h03000000, 32'hFFFFFFFF, 32'h80000000),
                     pk(32'hFFC00000, 32'h03000000, 32'hFFFFFFFF, 32'hF0000000)};
    tv[4] = '{2'b10, pk(32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'h00000000),
                     pk(32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'h00000000)};
    tv[5] = '{2'b00, pk(32'h00FFFFFF, 32'h025FFFFF, 32'h04FFFFFF, 32'h05000000),
                     pk(32'h00BFFFFF, 32'h00EBFFFF, 32'h00FFFFFF, 32'h01000000)};
    tv[6] = '{2'b00, pk(32'hFDA00000, 32'hFF800000, 32'hFD000000, 32'hFB000000),
                     pk(32'h00150000, 32'h00600000, 32'h00100000, 32'h00000000)};

    reset = 1'b0; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    mode = 2'b00; in_data = '0; sat_clr = 1'b0;
    #12;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_sat_cnt", W'(sat_cnt), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    reset = 1'b1;
    step();

    // Single beats from the table, with latency checks.
    for (int i = 0; i < 7; i++) begin
      send(tv[i].m, tv[i].din, tv[i].dout);
      chk("lat_s1_empty", W'(out_valid), W'(0));
      step();
      chk("lat_out_valid", W'(out_valid), W'(1));
      chk("table_out", out_data, tv[i].dout);
      step();
    end
    step();
    chk("sat_after_table", W'(sat_cnt), W'(SATEN ? 6 : 0));

    // Mode change on consecutive beats.
    send(2'b01, pk(32'hFE000000, 32'h03000000, 32'h0, 32'h0), pk(32'h00000000, 32'h03000000, 32'h0, 32'h0));
    send(2'b11, pk(32'hFE000000, 32'h03000000, 32'h0, 32'h0), pk(32'hFFC00000, 32'h03000000, 32'h0, 32'h0));
    chk("mode_relu", out_data, pk(32'h00000000, 32'h03000000, 32'h0, 32'h0));
    step();
    chk("mode_leaky", out_data, pk(32'hFFC00000, 32'h03000000, 32'h0, 32'h0));
    drain();

    // Back-pressure: out_ready low in cycles 3..6 of a 5-beat stream.
    fork
      begin
        for (int i = 0; i < 5; i++) send(tv[i].m, tv[i].din, tv[i].dout);
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          #1;
          if (c >= 3 && c <= 6) begin
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_held", out_data, tv[0].dout);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // en low for three cycles mid-stream.
    fork
      begin
        send(tv[5].m, tv[5].din, tv[5].dout);
        send(tv[6].m, tv[6].din, tv[6].dout);
        send(tv[0].m, tv[0].din, tv[0].dout);
        send(tv[1].m, tv[1].din, tv[1].dout);
      end
      begin
        for (int c = 1; c <= 10; c++) begin
          en = !(c >= 3 && c <= 5);
          #1;
          if (c >= 3 && c <= 5) begin
            chk("en_in_ready", W'(in_ready), W'(0));
            chk("en_out_valid", W'(out_valid), W'(1));
            chk("en_held", out_data, tv[5].dout);
          end
          @(posedge clk); #1;
        end
        en = 1'b1;
      end
    join
    drain();

    // Saturation counter: clear, count, clear-beats-increment, saturate.
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("sat_clear", W'(sat_cnt), W'(0));
    send(tv[1].m, tv[1].din, tv[1].dout);
    drain();
    chk("sat_count4", W'(sat_cnt), W'(SATEN ? 4 : 0));
    send(tv[1].m, tv[1].din, tv[1].dout);
    step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("sat_clr_wins", W'(sat_cnt), W'(0));
    drain();
    for (int i = 0; i < 16384; i++) send(tv[1].m, tv[1].din, tv[1].dout);
    drain();
    chk("sat_ceiling", W'(sat_cnt), W'(SATEN ? 16'hFFFF : 0));

    // Reset with two beats in flight.
    send(tv[0].m, tv[0].din, tv[0].dout);
    send(tv[4].m, tv[4].din, tv[4].dout);
    reset = 1'b0;
    #1;
    chk("mrst_out_valid", W'(out_valid), W'(0));
    chk("mrst_out_data", out_data, W'(0));
    chk("mrst_sat_cnt", W'(sat_cnt), W'(0));
    chk("mrst_in_ready", W'(in_ready), W'(0));
    discarded = exp_q.size();
    exp_q.delete();
    step();
    reset = 1'b1;
    step();
    chk("mrst_idle", W'(out_valid), W'(0));
    send(tv[6].m, tv[6].din, tv[6].dout);
    chk("mrst_lat1", W'(out_valid), W'(0));
    step();
    chk("mrst_lat2", W'(out_valid), W'(1));
    chk("mrst_data", out_data, tv[6].dout);
    drain();

    chk("beat_count", W'(rx_cnt), W'(tx_cnt - discarded));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
